// File: rtl/pipeline_control_pkg.sv
// rtl/pipeline_control_pkg.sv - shared constants for the pipeline control slice
package pipeline_control_pkg;

   // Default widths of register numbers and the ALU op code
   localparam int PC_REG_ADDR_W = 5;
   localparam int PC_ALU_OP_W   = 3;

   // ALU operand source select
   typedef enum logic [1:0] {
      FWD_REGFILE = 2'b00,
      FWD_WB      = 2'b01,
      FWD_MEM     = 2'b10
   } fwd_sel_e;

   // Control bundle slices: EX {alu_op, alu_src, reg_dst},
   // M {branch, mem_read, mem_write}, WB {reg_write, mem_to_reg}
   localparam int CTRL_EX_W = PC_ALU_OP_W + 2;
   localparam int CTRL_M_W  = 3;
   localparam int CTRL_WB_W = 2;
   localparam int CTRL_W    = CTRL_EX_W + CTRL_M_W + CTRL_WB_W;

   // A NOP travelling down the pipe is simply an all-zero bundle
   localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipeline_control_if.sv
// rtl/pipeline_control_if.sv - decoder/datapath bundle of pipeline_control
interface pipeline_control_if #(
   parameter int REG_ADDR_W = pipeline_control_pkg::PC_REG_ADDR_W,
   parameter int ALU_OP_W   = pipeline_control_pkg::PC_ALU_OP_W
);
   // Decoded instruction in ID
   logic                  id_branch;
   logic                  id_reg_dst;
   logic                  id_alu_src;
   logic                  id_mem_read;
   logic                  id_mem_write;
   logic                  id_reg_write;
   logic                  id_mem_to_reg;
   logic [ALU_OP_W-1:0]   id_alu_op;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_uses_rt;
   logic                  ex_zero;

   // Stage controls back to the datapath
   logic [ALU_OP_W-1:0]   ex_alu_op;
   logic                  ex_alu_src;
   logic                  ex_reg_dst;
   logic [REG_ADDR_W-1:0] ex_rs;
   logic [REG_ADDR_W-1:0] ex_rt;
   logic                  mem_mem_read;
   logic                  mem_mem_write;
   logic                  mem_pc_src;
   logic [REG_ADDR_W-1:0] mem_write_reg;
   logic                  wb_reg_write;
   logic                  wb_mem_to_reg;
   logic [REG_ADDR_W-1:0] wb_write_reg;
   logic [1:0]            fwd_a;
   logic [1:0]            fwd_b;
   logic                  pc_write;
   logic                  if_id_write;
   logic                  if_id_flush;

   modport slave (
      input  id_branch, id_reg_dst, id_alu_src, id_mem_read, id_mem_write,
             id_reg_write, id_mem_to_reg, id_alu_op, id_rs, id_rt, id_rd,
             id_uses_rt, ex_zero,
      output ex_alu_op, ex_alu_src, ex_reg_dst, ex_rs, ex_rt,
             mem_mem_read, mem_mem_write, mem_pc_src, mem_write_reg,
             wb_reg_write, wb_mem_to_reg, wb_write_reg,
             fwd_a, fwd_b, pc_write, if_id_write, if_id_flush
   );

   modport master (
      output id_branch, id_reg_dst, id_alu_src, id_mem_read, id_mem_write,
             id_reg_write, id_mem_to_reg, id_alu_op, id_rs, id_rt, id_rd,
             id_uses_rt, ex_zero,
      input  ex_alu_op, ex_alu_src, ex_reg_dst, ex_rs, ex_rt,
             mem_mem_read, mem_mem_write, mem_pc_src, mem_write_reg,
             wb_reg_write, wb_mem_to_reg, wb_write_reg,
             fwd_a, fwd_b, pc_write, if_id_write, if_id_flush
   );

endinterface

// File: rtl/pipeline_control_forwarding_unit.sv
// rtl/pipeline_control_forwarding_unit.sv - ALU operand forwarding selects
module forwarding_unit
   import pipeline_control_pkg::*;
#(
   parameter int REG_ADDR_W = PC_REG_ADDR_W
) (
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_write_reg,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_write_reg,
   input  logic [REG_ADDR_W-1:0] ex_rs,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   output fwd_sel_e              fwd_a,
   output fwd_sel_e              fwd_b
);

   logic mem_valid;
   logic wb_valid;

   // $0 is hardwired, so a write to it is never forwarded
   assign mem_valid = mem_reg_write && (mem_write_reg != '0);
   assign wb_valid  = wb_reg_write  && (wb_write_reg  != '0);

   // Pick the youngest producer of each EX source; MEM is younger than WB
   always_comb begin
      fwd_a = FWD_REGFILE;
      fwd_b = FWD_REGFILE;
      if (mem_valid && (mem_write_reg == ex_rs)) begin
         fwd_a = FWD_MEM;
      end else if (wb_valid && (wb_write_reg == ex_rs)) begin
         fwd_a = FWD_WB;
      end
      if (mem_valid && (mem_write_reg == ex_rt)) begin
         fwd_b = FWD_MEM;
      end else if (wb_valid && (wb_write_reg == ex_rt)) begin
         fwd_b = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - control stage registers, hazard and branch handling
module pipeline_control
   import pipeline_control_pkg::*;
#(
   parameter int REG_ADDR_W = PC_REG_ADDR_W,
   parameter int ALU_OP_W   = PC_ALU_OP_W
) (
   input  logic              clk,
   input  logic              reset,
   pipeline_control_if.slave bus
);

   localparam int EX_W = ALU_OP_W + CTRL_EX_W - PC_ALU_OP_W;
   localparam int BW   = EX_W + CTRL_M_W + CTRL_WB_W;

   // ID/EX
   logic [BW-1:0]         id_ctrl;
   logic [BW-1:0]         idex_ctrl;
   logic [REG_ADDR_W-1:0] idex_rs;
   logic [REG_ADDR_W-1:0] idex_rt;
   logic [REG_ADDR_W-1:0] idex_rd;
   logic [ALU_OP_W-1:0]   ex_alu_op;
   logic                  ex_alu_src;
   logic                  ex_reg_dst;
   logic                  ex_branch;
   logic                  ex_mem_read;
   logic                  ex_mem_write;
   logic                  ex_reg_write;
   logic                  ex_mem_to_reg;
   logic [REG_ADDR_W-1:0] ex_write_reg;

   // EX/MEM
   logic                  mem_branch;
   logic                  mem_zero;
   logic                  mem_mem_read;
   logic                  mem_mem_write;
   logic                  mem_reg_write;
   logic                  mem_mem_to_reg;
   logic [REG_ADDR_W-1:0] mem_write_reg;

   // MEM/WB
   logic                  wb_reg_write;
   logic                  wb_mem_to_reg;
   logic [REG_ADDR_W-1:0] wb_write_reg;

   logic                  load_use;
   logic                  branch_taken;
   logic                  stall;
   fwd_sel_e              fwd_a;
   fwd_sel_e              fwd_b;

   assign id_ctrl = {bus.id_alu_op, bus.id_alu_src, bus.id_reg_dst,
                     bus.id_branch, bus.id_mem_read, bus.id_mem_write,
                     bus.id_reg_write, bus.id_mem_to_reg};

   assign {ex_alu_op, ex_alu_src, ex_reg_dst, ex_branch, ex_mem_read,
           ex_mem_write, ex_reg_write, ex_mem_to_reg} = idex_ctrl;

   assign ex_write_reg = ex_reg_dst ? idex_rd : idex_rt;

   // A load in EX whose target ($0 excluded) is read by the instruction in ID
   assign load_use = ex_mem_read && (idex_rt != '0) &&
                     ((idex_rt == bus.id_rs) ||
                      (bus.id_uses_rt && (idex_rt == bus.id_rt)));

   assign branch_taken = mem_branch && mem_zero;

   // A taken branch redirects the PC anyway, so it overrides the stall
   assign stall = load_use && !branch_taken;

   // ID/EX stage register: bubble on reset, taken-branch flush or load-use stall
   always_ff @(posedge clk) begin
      if (reset || branch_taken || load_use) begin
         idex_ctrl <= BW'(CTRL_BUBBLE);
         idex_rs   <= '0;
         idex_rt   <= '0;
         idex_rd   <= '0;
      end else begin
         idex_ctrl <= id_ctrl;
         idex_rs   <= bus.id_rs;
         idex_rt   <= bus.id_rt;
         idex_rd   <= bus.id_rd;
      end
   end

   // EX/MEM stage register: bubble on reset or taken-branch flush
   always_ff @(posedge clk) begin
      if (reset || branch_taken) begin
         mem_branch     <= 1'b0;
         mem_zero       <= 1'b0;
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
         mem_reg_write  <= 1'b0;
         mem_mem_to_reg <= 1'b0;
         mem_write_reg  <= '0;
      end else begin
         mem_branch     <= ex_branch;
         mem_zero       <= bus.ex_zero;
         mem_mem_read   <= ex_mem_read;
         mem_mem_write  <= ex_mem_write;
         mem_reg_write  <= ex_reg_write;
         mem_mem_to_reg <= ex_mem_to_reg;
         mem_write_reg  <= ex_write_reg;
      end
   end

   // MEM/WB stage register: the branch in MEM has already resolved, always advance
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_reg_write  <= 1'b0;
         wb_mem_to_reg <= 1'b0;
         wb_write_reg  <= '0;
      end else begin
         wb_reg_write  <= mem_reg_write;
         wb_mem_to_reg <= mem_mem_to_reg;
         wb_write_reg  <= mem_write_reg;
      end
   end

   forwarding_unit #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_forwarding_unit (
      .mem_reg_write (mem_reg_write),
      .mem_write_reg (mem_write_reg),
      .wb_reg_write  (wb_reg_write),
      .wb_write_reg  (wb_write_reg),
      .ex_rs         (idex_rs),
      .ex_rt         (idex_rt),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b)
   );

   assign bus.ex_alu_op     = ex_alu_op;
   assign bus.ex_alu_src    = ex_alu_src;
   assign bus.ex_reg_dst    = ex_reg_dst;
   assign bus.ex_rs         = idex_rs;
   assign bus.ex_rt         = idex_rt;
   assign bus.mem_mem_read  = mem_mem_read;
   assign bus.mem_mem_write = mem_mem_write;
   assign bus.mem_pc_src    = branch_taken;
   assign bus.mem_write_reg = mem_write_reg;
   assign bus.wb_reg_write  = wb_reg_write;
   assign bus.wb_mem_to_reg = wb_mem_to_reg;
   assign bus.wb_write_reg  = wb_write_reg;
   assign bus.fwd_a         = fwd_a;
   assign bus.fwd_b         = fwd_b;
   assign bus.pc_write      = !stall;
   assign bus.if_id_write   = !stall;
   assign bus.if_id_flush   = branch_taken;

endmodule

// File: tb/tb_pipeline_control.sv
// tb/tb_pipeline_control.sv - scoreboard bench for pipeline_control
module tb_pipeline_control;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pipeline_control_if #(.REG_ADDR_W(5), .ALU_OP_W(3)) bus ();

   pipeline_control #(.REG_ADDR_W(5), .ALU_OP_W(3)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   typedef struct packed {
      logic       branch;
      logic       reg_dst;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       uses_rt;
      logic [2:0] alu_op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
   } instr_t;

   typedef enum int {
      S_EX_ALU_OP, S_EX_ALU_SRC, S_EX_REG_DST, S_EX_RS, S_EX_RT,
      S_MEM_READ, S_MEM_WRITE, S_PC_SRC, S_MEM_WR_REG,
      S_WB_REG_WRITE, S_WB_MEM_TO_REG, S_WB_WR_REG,
      S_FWD_A, S_FWD_B, S_PC_WRITE, S_IF_ID_WRITE, S_FLUSH, S_NUM
   } sig_e;

   typedef struct {
      int   cyc;
      sig_e sig;
      int   val;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   n_checks;
   int   n_fail;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sample(sig_e s);
      case (s)
         S_EX_ALU_OP:     return 32'(bus.ex_alu_op);
         S_EX_ALU_SRC:    return 32'(bus.ex_alu_src);
         S_EX_REG_DST:    return 32'(bus.ex_reg_dst);
         S_EX_RS:         return 32'(bus.ex_rs);
         S_EX_RT:         return 32'(bus.ex_rt);
         S_MEM_READ:      return 32'(bus.mem_mem_read);
         S_MEM_WRITE:     return 32'(bus.mem_mem_write);
         S_PC_SRC:        return 32'(bus.mem_pc_src);
         S_MEM_WR_REG:    return 32'(bus.mem_write_reg);
         S_WB_REG_WRITE:  return 32'(bus.wb_reg_write);
         S_WB_MEM_TO_REG: return 32'(bus.wb_mem_to_reg);
         S_WB_WR_REG:     return 32'(bus.wb_write_reg);
         S_FWD_A:         return 32'(bus.fwd_a);
         S_FWD_B:         return 32'(bus.fwd_b);
         S_PC_WRITE:      return 32'(bus.pc_write);
         S_IF_ID_WRITE:   return 32'(bus.if_id_write);
         S_FLUSH:         return 32'(bus.if_id_flush);
         default:         return 'x;
      endcase
   endfunction

   task automatic exp_at(int c, sig_e s, int v);
      exp_t e;
      e.cyc = c;
      e.sig = s;
      e.val = v;
      sb.push_back(e);
   endtask

   // Compare and retire every scoreboard entry due in the current cycle
   task automatic scan();
      for (int i = sb.size() - 1; i >= 0; i--) begin
         sig_e s;
         s = sb[i].sig;
         if (sb[i].cyc == cyc) begin
            check($sformatf("%s@%0d", s.name(), cyc), sample(s), sb[i].val);
            sb.delete(i);
         end
      end
   endtask

   function automatic instr_t mk_nop();
      instr_t i = '0;
      return i;
   endfunction

   function automatic instr_t mk_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
      instr_t i = '0;
      i.reg_dst = 1'b1; i.reg_write = 1'b1; i.uses_rt = 1'b1; i.alu_op = 3'b010;
      i.rs = rs; i.rt = rt; i.rd = rd;
      return i;
   endfunction

   function automatic instr_t mk_lw(logic [4:0] rs, logic [4:0] rt);
      instr_t i = '0;
      i.alu_src = 1'b1; i.mem_read = 1'b1; i.reg_write = 1'b1; i.mem_to_reg = 1'b1;
      i.rs = rs; i.rt = rt; i.rd = 5'd5;
      return i;
   endfunction

   function automatic instr_t mk_addi(logic [4:0] rs, logic [4:0] rt);
      instr_t i = '0;
      i.alu_src = 1'b1; i.reg_write = 1'b1;
      i.rs = rs; i.rt = rt;
      return i;
   endfunction

   function automatic instr_t mk_beq(logic [4:0] rs, logic [4:0] rt);
      instr_t i = '0;
      i.branch = 1'b1; i.uses_rt = 1'b1; i.alu_op = 3'b001;
      i.rs = rs; i.rt = rt;
      return i;
   endfunction

   task automatic drive(instr_t i, logic z);
      bus.id_branch     = i.branch;
      bus.id_reg_dst    = i.reg_dst;
      bus.id_alu_src    = i.alu_src;
      bus.id_mem_read   = i.mem_read;
      bus.id_mem_write  = i.mem_write;
      bus.id_reg_write  = i.reg_write;
      bus.id_mem_to_reg = i.mem_to_reg;
      bus.id_uses_rt    = i.uses_rt;
      bus.id_alu_op     = i.alu_op;
      bus.id_rs         = i.rs;
      bus.id_rt         = i.rt;
      bus.id_rd         = i.rd;
      bus.ex_zero       = z;
   endtask

   // One cycle: present inputs, check at the falling edge, then clock
   task automatic run(instr_t i, logic z);
      drive(i, z);
      @(negedge clk);
      scan();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(int n);
      repeat (n) run(mk_nop(), 1'b0);
   endtask

   initial begin
      int b;
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      rst      = 1'b1;
      drive(mk_lw(5'd1, 5'd8), 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state with NOP input
      for (int k = 0; k < S_NUM; k++) begin
         exp_at(0, sig_e'(k), (k == S_PC_WRITE || k == S_IF_ID_WRITE) ? 1 : 0);
      end
      run(mk_nop(), 1'b0);

      // R-type add flowing to WB
      b = cyc;
      exp_at(b+1, S_EX_REG_DST, 1); exp_at(b+1, S_EX_ALU_OP, 2);
      exp_at(b+1, S_EX_RS, 1);      exp_at(b+1, S_EX_RT, 2);
      exp_at(b+1, S_EX_ALU_SRC, 0);
      exp_at(b+2, S_MEM_WR_REG, 3); exp_at(b+2, S_WB_REG_WRITE, 0);
      exp_at(b+3, S_WB_REG_WRITE, 1); exp_at(b+3, S_WB_WR_REG, 3);
      exp_at(b+3, S_WB_MEM_TO_REG, 0);
      run(mk_r(5'd1, 5'd2, 5'd3), 1'b0);
      idle(4);

      // lw r8 then add using r8: one stall cycle, bubble, then WB forward
      b = cyc;
      exp_at(b+0, S_PC_WRITE, 1);
      exp_at(b+1, S_PC_WRITE, 0); exp_at(b+1, S_IF_ID_WRITE, 0);
      exp_at(b+1, S_EX_ALU_SRC, 1);
      exp_at(b+2, S_PC_WRITE, 1); exp_at(b+2, S_IF_ID_WRITE, 1);
      exp_at(b+2, S_EX_ALU_SRC, 0); exp_at(b+2, S_EX_ALU_OP, 0);
      exp_at(b+2, S_EX_REG_DST, 0); exp_at(b+2, S_EX_RS, 0); exp_at(b+2, S_EX_RT, 0);
      exp_at(b+2, S_MEM_READ, 1); exp_at(b+2, S_MEM_WR_REG, 8);
      exp_at(b+3, S_EX_RS, 8); exp_at(b+3, S_EX_RT, 9);
      exp_at(b+3, S_FWD_A, 1); exp_at(b+3, S_FWD_B, 0);
      exp_at(b+3, S_MEM_READ, 0); exp_at(b+3, S_WB_MEM_TO_REG, 1);
      exp_at(b+3, S_WB_WR_REG, 8);
      exp_at(b+4, S_MEM_WR_REG, 10);
      run(mk_lw(5'd1, 5'd8), 1'b0);
      run(mk_r(5'd8, 5'd9, 5'd10), 1'b0);
      run(mk_r(5'd8, 5'd9, 5'd10), 1'b0);
      idle(4);

      // No stall: rt match without uses_rt, and a load into $0
      b = cyc;
      exp_at(b+1, S_PC_WRITE, 1);
      exp_at(b+2, S_EX_RT, 8); exp_at(b+2, S_EX_ALU_SRC, 1);
      exp_at(b+3, S_PC_WRITE, 1); exp_at(b+3, S_MEM_WR_REG, 8);
      run(mk_lw(5'd1, 5'd8), 1'b0);
      run(mk_addi(5'd2, 5'd8), 1'b0);
      run(mk_lw(5'd1, 5'd0), 1'b0);
      run(mk_r(5'd0, 5'd0, 5'd4), 1'b0);
      idle(4);

      // MEM forwarding on both operands
      b = cyc;
      exp_at(b+2, S_EX_RS, 3); exp_at(b+2, S_FWD_A, 2); exp_at(b+2, S_FWD_B, 2);
      exp_at(b+3, S_FWD_A, 0);
      run(mk_r(5'd1, 5'd2, 5'd3), 1'b0);
      run(mk_r(5'd3, 5'd3, 5'd4), 1'b0);
      idle(4);

      // Writes to $0 are never forwarded
      b = cyc;
      exp_at(b+2, S_FWD_A, 0); exp_at(b+2, S_FWD_B, 0);
      run(mk_r(5'd1, 5'd2, 5'd0), 1'b0);
      run(mk_r(5'd0, 5'd0, 5'd5), 1'b0);
      idle(4);

      // MEM wins over WB for the same register
      b = cyc;
      exp_at(b+3, S_FWD_A, 2); exp_at(b+3, S_FWD_B, 2);
      run(mk_r(5'd1, 5'd2, 5'd3), 1'b0);
      run(mk_r(5'd5, 5'd6, 5'd3), 1'b0);
      run(mk_r(5'd3, 5'd3, 5'd7), 1'b0);
      idle(4);

      // Mixed: rs from MEM, rt from WB
      b = cyc;
      exp_at(b+3, S_FWD_A, 2); exp_at(b+3, S_FWD_B, 1);
      run(mk_r(5'd1, 5'd2, 5'd4), 1'b0);
      run(mk_r(5'd1, 5'd2, 5'd6), 1'b0);
      run(mk_r(5'd6, 5'd4, 5'd7), 1'b0);
      idle(4);

      // Taken beq: flush for one cycle, younger stages squashed
      b = cyc;
      exp_at(b+1, S_PC_SRC, 0); exp_at(b+1, S_EX_REG_DST, 0);
      exp_at(b+2, S_PC_SRC, 1); exp_at(b+2, S_FLUSH, 1); exp_at(b+2, S_PC_WRITE, 1);
      exp_at(b+2, S_EX_REG_DST, 1); exp_at(b+2, S_MEM_WR_REG, 2);
      exp_at(b+3, S_PC_SRC, 0); exp_at(b+3, S_FLUSH, 0);
      exp_at(b+3, S_EX_REG_DST, 0); exp_at(b+3, S_EX_ALU_OP, 0); exp_at(b+3, S_EX_RS, 0);
      exp_at(b+3, S_MEM_READ, 0); exp_at(b+3, S_MEM_WRITE, 0);
      exp_at(b+3, S_MEM_WR_REG, 0); exp_at(b+3, S_WB_WR_REG, 2);
      exp_at(b+3, S_WB_REG_WRITE, 0);
      run(mk_beq(5'd1, 5'd2), 1'b0);
      run(mk_r(5'd1, 5'd2, 5'd7), 1'b1);
      run(mk_r(5'd3, 5'd4, 5'd9), 1'b0);
      idle(4);

      // Not-taken beq: no flush, younger instructions flow on
      b = cyc;
      exp_at(b+2, S_PC_SRC, 0); exp_at(b+2, S_FLUSH, 0);
      exp_at(b+3, S_EX_REG_DST, 1); exp_at(b+3, S_EX_RS, 3); exp_at(b+3, S_MEM_WR_REG, 7);
      run(mk_beq(5'd1, 5'd2), 1'b0);
      run(mk_r(5'd1, 5'd2, 5'd7), 1'b0);
      run(mk_r(5'd3, 5'd4, 5'd9), 1'b0);
      idle(4);

      // Taken branch coinciding with load-use: branch wins
      b = cyc;
      exp_at(b+2, S_PC_SRC, 1); exp_at(b+2, S_FLUSH, 1);
      exp_at(b+2, S_PC_WRITE, 1); exp_at(b+2, S_IF_ID_WRITE, 1);
      exp_at(b+2, S_EX_ALU_SRC, 1);
      exp_at(b+3, S_EX_ALU_SRC, 0); exp_at(b+3, S_EX_RS, 0);
      exp_at(b+3, S_MEM_READ, 0); exp_at(b+3, S_PC_WRITE, 1);
      run(mk_beq(5'd1, 5'd2), 1'b0);
      run(mk_lw(5'd1, 5'd8), 1'b1);
      run(mk_r(5'd8, 5'd9, 5'd10), 1'b0);
      idle(4);

      // Reset during a load-use stall
      b = cyc;
      exp_at(b+1, S_PC_WRITE, 0);
      exp_at(b+2, S_PC_WRITE, 1); exp_at(b+2, S_IF_ID_WRITE, 1);
      exp_at(b+2, S_EX_ALU_SRC, 0); exp_at(b+2, S_EX_RS, 0); exp_at(b+2, S_EX_RT, 0);
      exp_at(b+2, S_MEM_READ, 0); exp_at(b+2, S_MEM_WR_REG, 0);
      exp_at(b+2, S_WB_WR_REG, 0);
      exp_at(b+3, S_EX_RS, 8); exp_at(b+3, S_FWD_A, 0);
      run(mk_lw(5'd1, 5'd8), 1'b0);
      rst = 1'b1;
      run(mk_r(5'd8, 5'd9, 5'd10), 1'b0);
      rst = 1'b0;
      run(mk_r(5'd8, 5'd9, 5'd10), 1'b0);
      idle(4);

      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
Receiving end of the instruction decoder's control bundle. It carries the decoded EX/M/WB control signals and register numbers through the ID/EX, EX/MEM and MEM/WB stage registers. It also detects load-use hazards, stalling and inserting bubbles as needed, resolves taken branches in MEM and flushes younger stages. It generates the ALU operand forwarding selects, and sits between the decoder and the datapath stage registers of the 5-stage pipeline.

Parameters:
REG_ADDR_W, 5, register-number width
ALU_OP_W, 3, width of alu_op code

Ports:
clk  in  1  rising-edge clock
reset  in  1  reset, synchronous, active-high
id_branch, id_reg_dst, id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1 each  decoder controls for instruction in ID
id_alu_op  in  ALU_OP_W  decoder ALU op
id_rs, id_rt, id_rd  in  REG_ADDR_W  register fields of ID instruction
id_uses_rt  in  1  rt is a source operand (R-type, BEQ, SW)
ex_zero  in  1  ALU zero flag of instruction in EX
ex_alu_op  out  ALU_OP_W  EX-stage ALU op
ex_alu_src, ex_reg_dst  out  1  EX-stage controls
ex_rs, ex_rt  out  REG_ADDR_W  EX-stage source registers
mem_mem_read, mem_mem_write  out  1  MEM-stage controls
mem_pc_src  out  1  taken branch: mem_branch & mem_zero
mem_write_reg  out  REG_ADDR_W  destination in MEM
wb_reg_write, wb_mem_to_reg  out  1  WB-stage controls
wb_write_reg  out  REG_ADDR_W  destination in WB
fwd_a, fwd_b  out  2  operand select: 00 regfile, 10 from MEM, 01 from WB
pc_write, if_id_write  out  1  PC / IF-ID enables (0 = stall)
if_id_flush  out  1  clear IF/ID on next edge

Behaviour:
- Stage registers: ID/EX {alu_op, alu_src, reg_dst, branch, mem_read, mem_write, reg_write, mem_to_reg, rs, rt, rd}. EX/MEM {branch, zero, mem_read, mem_write, reg_write, mem_to_reg, write_reg}. MEM/WB {reg_write, mem_to_reg, write_reg}.
- Latency: ID to EX 1 cycle, EX to MEM 1 cycle, MEM to WB 1 cycle.
- ex_write_reg = ex_reg_dst ? ex_rd : ex_rt, computed combinationally. It is registered into mem_write_reg.
- Reset: at the clock edge with reset=1, all stage registers clear to 0 (NOP bundle), regardless of stall or flush.
  - Resulting outputs: every control and register-number output is 0.
  - fwd_a = fwd_b = 00, pc_write = if_id_write = 1, if_id_flush = 0, mem_pc_src = 0.
- Load-use hazard:
  - Condition: load_use = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
  - Response: pc_write = 0 and if_id_write = 0, combinationally in the same cycle.
  - Next edge: ID/EX loads the all-zero bundle (bubble). EX/MEM and MEM/WB advance normally.
  - The stall lasts exactly one cycle, because the bubble clears ex_mem_read.
- Taken branch:
  - Condition: mem_pc_src = mem_branch & mem_zero, combinational from EX/MEM.
  - When 1: if_id_flush = 1. On the next edge, ID/EX and EX/MEM load bubbles. MEM/WB advances normally.
- Simultaneous taken branch and load-use: the branch wins.
  - pc_write = 1 and if_id_write = 1, so the PC loads the target.
  - The bubble in ID/EX comes from the flush.
- Forwarding (combinational):
  - fwd_a = 10 if mem_reg_write & mem_write_reg != 0 & mem_write_reg == ex_rs.
  - Otherwise fwd_a = 01 if wb_reg_write & wb_write_reg != 0 & wb_write_reg == ex_rs.
  - Otherwise fwd_a = 00.
  - fwd_b uses the same rule with ex_rt. MEM has priority over WB.
- Register $0 is never a hazard or forward source.
- No X propagation: an X bundle from the decoder (undefined opcode) is passed through unchanged. Containing it is not this block's responsibility.

Decomposition:
- Shared header (alongside the existing opcode and ALU-op headers) holds:
  - FWD_REGFILE = 2'b00, FWD_MEM = 2'b10, FWD_WB = 2'b01.
  - Control-bundle widths CTRL_EX_W, CTRL_M_W, CTRL_WB_W.
  - The all-zero bubble constant.
- Sub-module: forwarding_unit (combinational fwd_a/fwd_b logic), instantiated once.
- Hazard detection and the stage registers stay in pipeline_control.

Test Plan:
1. Reset held 2 cycles, then released with NOP input -> every control/register output is 0, fwd = 00, pc_write = 1, if_id_flush = 0.
2. R-type add (alu_op R-type, reg_dst = 1, reg_write = 1, rd = 3) at cycle 0 -> ex_reg_dst = 1 at cycle 1; mem_write_reg = 3 at cycle 2; wb_reg_write = 1 and wb_write_reg = 3 at cycle 3.
3. lw rt = 8, then add rs = 8 -> pc_write = 0 for exactly one cycle, then a bubble in EX (all ex controls 0). When the add reaches EX, fwd_a = 01.
4. add rd = 3, then sub rs = 3 rt = 3 -> fwd_a = fwd_b = 10. The same sequence with rd = 0 -> fwd_a = fwd_b = 00.
5. beq with ex_zero = 1 -> mem_pc_src = 1 and if_id_flush = 1 for one cycle; the following cycle has ex and mem controls 0. With ex_zero = 0 there is no flush. A taken branch coinciding with load-use gives pc_write = 1.
6. Reset asserted during a load-use stall -> all stage registers are 0 after that edge and pc_write = 1.
